div_sequencer: RTL and testbench
================================

Name: div_sequencer

Overview:
Controls the execute stage's shared 32-bit iterative divider. It accepts one divide/modulo request at a time from the EX stage and sequences a radix-2 restoring shift-subtract datapath, one quotient bit per cycle. It applies the sign fix-up and holds the result until the stage accepts it. While a request is in flight it drives `div_ok` low so the EX stage stalls, and it aborts cleanly on a pipeline flush.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  EX holds a valid, non-excepting div/mod instruction.
- req_signed  in  1  1 = signed operation (div.w/mod.w); 0 = unsigned (div.wu/mod.wu).
- req_use_mod  in  1  1 = return remainder; 0 = return quotient.
- req_x  in  XLEN  dividend.
- req_y  in  XLEN  divisor.
- flush  in  1  pipeline flush (branch mispredict or exception); aborts the operation.
- res_ready  in  1  downstream (WB) can take the result this cycle.
- div_ok  out  1  no stall needed: idle with no request pending, or result presented.
- res_valid  out  1  result valid; this is the DONE state.
- result  out  XLEN  quotient or remainder.
- busy  out  1  state is CALC.

Behaviour:
- Reset (clk, reset: synchronous, active-high) sets:
  - state=IDLE, counter=0, result=0, res_valid=0, busy=0.
  - div_ok=1 whenever req_valid=0.
- States:
  - IDLE: on req_valid & ~flush, latch the operands.
    - Signed ops: latch |x|, |y| and the sign flags sq=x[31]^y[31], sr=x[31].
    - Unsigned ops: latch x, y raw; sq=sr=0.
    - Set counter=XLEN, then go to CALC.
    - If y==0, go directly to DONE with quotient=all-ones and remainder=x (raw).
  - CALC: one step per cycle.
    - Step: partial remainder shifts left, subtract |y|, keep the difference if it is non-negative, shift in the quotient bit.
    - Counter decrements each step; when it reaches 1, go to DONE next.
  - DONE: res_valid=1.
    - result = use_mod ? (sr ? -rem : rem) : (sq ? -quo : quo).
    - Stay in DONE while res_ready=0. On res_ready=1, go to IDLE next cycle.
- Latency: accept in cycle 0, XLEN CALC cycles, res_valid in cycle XLEN+1. Divide-by-zero: res_valid in cycle 1.
- div_ok = (state==DONE) | (state==IDLE & ~req_valid). It is low in the accept cycle and throughout CALC.
- No re-accept: a request is sampled only in IDLE. DONE→IDLE happens only on res_ready, and EX advances the instruction in that same cycle.
- Overflow: -2^31 / -1 gives quotient 0x80000000 and remainder 0, a natural consequence of the magnitude path.
- flush in any state: next state is IDLE, res_valid=0, and the result is discarded.
  - If flush and req_valid arrive in the same IDLE cycle, the request is not accepted.
- Reset mid-operation behaves like flush and also clears the result register.
- Request inputs are ignored outside IDLE; the operands are latched.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if |x| < |y| (unsigned compare after abs), go directly to DONE with quotient=0 and remainder=x (raw sign). Latency is 1 cycle, same as divide-by-zero.
- Undefined: every non-zero divisor takes the full XLEN+1 cycles. Results are identical in both builds.

Decomposition:
- Package div_pkg:
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - DIV_ZERO_QUO constant (all-ones);
  - XLEN default.
- Sub-module div_core: combinational single iteration step.
  - Inputs: partial remainder, quotient, divisor.
  - Outputs: next remainder, next quotient.
  - Used by div_sequencer, which owns the registers, counter and FSM.

Test Plan:
- Signed 0xFFFFFFF9 (-7) / 2, use_mod=0, res_ready=1 → div_ok low for 33 cycles; result 0xFFFFFFFD (-3) with res_valid in cycle 33. Repeat with use_mod=1 → 0xFFFFFFFF (-1).
- Unsigned 0xFFFFFFF9 / 2 → 0x7FFFFFFC. Signed 0x80000000 / 0xFFFFFFFF → 0x80000000; with use_mod=1 → 0.
- 100 / 0, use_mod=0 → 0xFFFFFFFF in cycle 1. 100 mod 0 → 100.
- res_ready held 0 for 5 cycles after DONE → res_valid and result stable, div_ok=1, and no new accept while req_valid stays high. res_ready=1 → IDLE next cycle.
- Assert flush at CALC cycle 10 → IDLE next cycle, res_valid never rises. A new request (9/3) accepted afterwards returns 3 with full latency.
- With DIV_EARLY_OUT_EN: 3/10 → quotient 0 in cycle 1, and 3 mod 10 → 3. Without it, the same results arrive in cycle 33.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the execute-stage iterative divider: state encoding,
// the divide-by-zero quotient constant and the default operand width.
package div_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_core.sv
// One radix-2 restoring divide step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and shift in the quotient bit.
module div_core #(
  parameter int XLEN = div_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_div,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // The shifted remainder is always below twice the divisor, so only the low
  // XLEN bits of the difference are ever kept.
  assign w_shift = {i_rem, i_quo[XLEN-1]};
  assign w_ge    = (w_shift >= {1'b0, i_div});
  assign w_diff  = w_shift[XLEN-1:0] - i_div;
  assign o_rem   = w_ge ? w_diff : w_shift[XLEN-1:0];
  assign o_quo   = {i_quo[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_sequencer.sv
// Sequencer for the shared iterative divider: accepts one div/mod request,
// runs XLEN restoring steps, applies the sign fix-up and holds the result.
// Optional build macro DIV_EARLY_OUT_EN finishes in one cycle when |x| < |y|.
module div_sequencer #(
  parameter int XLEN  = div_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_signed,
  input  logic            req_use_mod,
  input  logic [XLEN-1:0] req_x,
  input  logic [XLEN-1:0] req_y,
  input  logic            flush,
  input  logic            res_ready,
  output logic            div_ok,
  output logic            res_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  import div_pkg::*;

  div_state_e       r_state;
  div_state_e       w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [XLEN-1:0]  r_result;
  logic             r_sq;
  logic             r_sr;
  logic             r_useMod;

  logic [XLEN-1:0]  w_absX;
  logic [XLEN-1:0]  w_absY;
  logic [XLEN-1:0]  w_nextRem;
  logic [XLEN-1:0]  w_nextQuo;
  logic [XLEN-1:0]  w_fixed;
  logic             w_divZero;
  logic             w_earlyOut;
  logic             w_accept;
  logic             w_lastStep;

  // Magnitudes of the most negative value stay correct as unsigned numbers.
  assign w_absX    = (req_signed && req_x[XLEN-1]) ? -req_x : req_x;
  assign w_absY    = (req_signed && req_y[XLEN-1]) ? -req_y : req_y;
  assign w_divZero = (req_y == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_earlyOut = (w_absX < w_absY);
`else
  assign w_earlyOut = 1'b0;
`endif

  assign w_accept   = (r_state == IDLE) && req_valid && !flush;
  assign w_lastStep = (r_state == CALC) && (r_cnt == CNT_W'(1));

  div_core #(.XLEN(XLEN)) u_core (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_nextRem),
    .o_quo (w_nextQuo)
  );

  assign w_fixed = r_useMod ? (r_sr ? -w_nextRem : w_nextRem)
                            : (r_sq ? -w_nextQuo : w_nextQuo);

  always_comb begin
    w_nextState = r_state;
    res_valid   = 1'b0;
    busy        = 1'b0;
    div_ok      = 1'b0;
    case (r_state)
      IDLE: begin
        div_ok = !req_valid;
        if (w_accept) begin
          w_nextState = (w_divZero || w_earlyOut) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        res_valid = 1'b1;
        div_ok    = 1'b1;
        if (res_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (flush) begin
      w_nextState = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Short-circuit cases (zero divisor, early out) load the final result at
  // accept time; the normal path loads it together with the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_sq     <= 1'b0;
      r_sr     <= 1'b0;
      r_useMod <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem    <= '0;
            r_quo    <= w_absX;
            r_div    <= w_absY;
            r_sq     <= req_signed && (req_x[XLEN-1] ^ req_y[XLEN-1]);
            r_sr     <= req_signed && req_x[XLEN-1];
            r_useMod <= req_use_mod;
            r_cnt    <= CNT_W'(XLEN);
            if (w_divZero) begin
              r_result <= req_use_mod ? req_x : XLEN'(DIV_ZERO_QUO);
            end else if (w_earlyOut) begin
              r_result <= req_use_mod ? req_x : '0;
            end
          end
        end
        CALC: begin
          r_rem <= w_nextRem;
          r_quo <= w_nextQuo;
          r_cnt <= r_cnt - CNT_W'(1);
          if (w_lastStep) begin
            r_result <= w_fixed;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed vector table, hand-written
// stall/flush/reset sequences and randomized ops against an arithmetic model.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_signed;
  logic        req_use_mod;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic        flush;
  logic        res_ready;
  logic        div_ok;
  logic        res_valid;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  typedef struct {
    string       name;
    bit          sgn;
    bit          useMod;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] expRes;
    int          expLat;
  } vec_t;

  vec_t vecs[10];

  div_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_signed  (req_signed),
    .req_use_mod (req_use_mod),
    .req_x       (req_x),
    .req_y       (req_y),
    .flush       (flush),
    .res_ready   (res_ready),
    .div_ok      (div_ok),
    .res_valid   (res_valid),
    .result      (result),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder
  // takes the dividend's sign; zero divisor gives all-ones / dividend.
  function automatic logic [31:0] modelResult(input bit sgn, input bit useMod,
                                              input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    if (y == 32'd0) return useMod ? x : 32'hFFFF_FFFF;
    if (sgn) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return useMod ? 32'(sx % sy) : 32'(sx / sy);
    end
    return useMod ? (x % y) : (x / y);
  endfunction

  function automatic int modelLatency(input bit sgn, input logic [31:0] x,
                                      input logic [31:0] y);
    longint ax;
    longint ay;
    if (y == 32'd0) return 1;
    ax = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    ay = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
`ifdef DIV_EARLY_OUT_EN
    if (ax < ay) return 1;
`endif
    return 33;
  endfunction

  // Issues one request and waits (bounded) for res_valid; reports result,
  // latency in cycles after accept, and whether div_ok stayed low meanwhile.
  task automatic applyStimulus(input bit sgn, input bit useMod, input logic [31:0] x,
                               input logic [31:0] y, output logic [31:0] res,
                               output int lat, output bit okLow);
    @(negedge clk);
    req_valid   = 1'b1;
    req_signed  = sgn;
    req_use_mod = useMod;
    req_x       = x;
    req_y       = y;
    lat   = 0;
    okLow = 1'b1;
    while (lat < 100) begin
      #1;
      if (res_valid === 1'b1) break;
      if (div_ok !== 1'b0) okLow = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end
    res = result;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] res;
    logic [31:0] x;
    logic [31:0] y;
    int          lat;
    bit          okLow;
    bit          sgn;
    bit          useMod;
    bit          seenValid;

    vecs[0] = '{"sdivNeg7by2",    1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vecs[1] = '{"smodNeg7by2",    1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vecs[2] = '{"udivFFF9by2",    1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 33};
    vecs[3] = '{"sdivOverflow",   1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[4] = '{"smodOverflow",   1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[5] = '{"udiv100by0",     1'b0, 1'b0, 32'd100,       32'd0,         32'hFFFF_FFFF, 1};
    vecs[6] = '{"umod100by0",     1'b0, 1'b1, 32'd100,       32'd0,         32'd100,       1};
    vecs[7] = '{"udiv3by10",      1'b0, 1'b0, 32'd3,         32'd10,        32'd0,         EARLY_LAT};
    vecs[8] = '{"umod3by10",      1'b0, 1'b1, 32'd3,         32'd10,        32'd3,         EARLY_LAT};
    vecs[9] = '{"sdiv7byNeg2",    1'b1, 1'b0, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_signed  = 1'b0;
    req_use_mod = 1'b0;
    req_x       = '0;
    req_y       = '0;
    flush       = 1'b0;
    res_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("resetResValid", {31'd0, res_valid}, 32'd0);
    checkOutput("resetBusy",     {31'd0, busy},      32'd0);
    checkOutput("resetResult",   result,             32'd0);
    checkOutput("resetDivOk",    {31'd0, div_ok},    32'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].useMod, vecs[i].x, vecs[i].y, res, lat, okLow);
      checkOutput({vecs[i].name, "_result"},  res, vecs[i].expRes);
      checkOutput({vecs[i].name, "_latency"}, lat, vecs[i].expLat);
      checkOutput({vecs[i].name, "_divOkLow"}, {31'd0, okLow}, 32'd1);
      checkOutput({vecs[i].name, "_divOkDone"}, {31'd0, div_ok}, 32'd1);
    end

    $display("[TB] stall in DONE with req_valid held high");
    @(negedge clk);
    res_ready   = 1'b0;
    req_valid   = 1'b1;
    req_signed  = 1'b0;
    req_use_mod = 1'b0;
    req_x       = 32'd20;
    req_y       = 32'd6;
    lat = 0;
    #1;
    while (res_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      req_x = $urandom;
      req_y = $urandom | 32'd1;
      lat++;
      #1;
    end
    checkOutput("stallLatency", lat, 33);
    checkOutput("stallResult",  result, 32'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("stallHoldValid",  {31'd0, res_valid}, 32'd1);
      checkOutput("stallHoldResult", result,             32'd3);
      checkOutput("stallHoldDivOk",  {31'd0, div_ok},    32'd1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("stallReleaseValid", {31'd0, res_valid}, 32'd0);
    checkOutput("stallReleaseBusy",  {31'd0, busy},      32'd0);

    $display("[TB] flush mid-calculation");
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 32'd1000;
    req_y     = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1;
    checkOutput("flushBusyBefore", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flushBusyAfter",  {31'd0, busy},      32'd0);
    checkOutput("flushValidAfter", {31'd0, res_valid}, 32'd0);
    seenValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (res_valid === 1'b1) seenValid = 1'b1;
    end
    checkOutput("flushNoValid", {31'd0, seenValid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'd9, 32'd3, res, lat, okLow);
    checkOutput("postFlushResult",  res, 32'd3);
    checkOutput("postFlushLatency", lat, 33);

    $display("[TB] flush together with request in IDLE");
    @(negedge clk);
    req_valid = 1'b1;
    flush     = 1'b1;
    req_x     = 32'd50;
    req_y     = 32'd5;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    #1;
    checkOutput("flushReqBusy",  {31'd0, busy},      32'd0);
    checkOutput("flushReqValid", {31'd0, res_valid}, 32'd0);

    $display("[TB] reset mid-calculation");
    @(negedge clk);
    req_valid = 1'b1;
    req_x     = 32'd77;
    req_y     = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midResetBusy",   {31'd0, busy},      32'd0);
    checkOutput("midResetValid",  {31'd0, res_valid}, 32'd0);
    checkOutput("midResetResult", result,             32'd0);
    checkOutput("midResetDivOk",  {31'd0, div_ok},    32'd1);

    $display("[TB] randomized operations against reference model");
    for (int i = 0; i < 24; i++) begin
      sgn    = 1'($urandom_range(0, 1));
      useMod = 1'($urandom_range(0, 1));
      x      = $urandom;
      case ($urandom_range(0, 3))
        0:       y = 32'd0;
        1:       y = 32'($urandom_range(1, 15));
        2:       y = $urandom;
        default: y = x >> $urandom_range(0, 31);
      endcase
      applyStimulus(sgn, useMod, x, y, res, lat, okLow);
      checkOutput("randResult",   res, modelResult(sgn, useMod, x, y));
      checkOutput("randLatency",  lat, modelLatency(sgn, x, y));
      checkOutput("randDivOkLow", {31'd0, okLow}, 32'd1);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
